// File: rtl/ripple_carry_adder_pkg.sv
// Shared arithmetic constants for the adder family.
// The default operand width lives here so that other adder variants can reuse it.
package ripple_carry_adder_pkg;

    localparam int unsigned RCA_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell.
// Purely combinational; it is chained by ripple_carry_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder built from a chain of full_adder cells.
// The sum and carry-out are registered, giving one cycle of latency.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    // Reset has priority over the add and discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH=4.
// Directed vectors are followed by an exhaustive sweep against a behavioural model.
module tb_ripple_carry_adder;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and record what the DUT must show after the next edge.
    task automatic apply(input logic r, input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic ci, input logic [W-1:0] es, input logic ec,
                         input string tag);
        exp_t item;
        @(negedge clk);
        rst = r;
        x   = xa;
        y   = ya;
        cin = ci;
        item.s    = es;
        item.cout = ec;
        item.tag  = tag;
        sb.push_back(item);
    endtask

    // Monitor: every edge after stimulus has been queued produces one result.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({cout, s} !== {e.cout, e.s}) begin
                    failures++;
                    $display("FAIL %s: got s=%b cout=%b, expected s=%b cout=%b",
                             e.tag, s, cout, e.s, e.cout);
                end
            end
        end
    end

    initial begin
        logic [W:0] model;
        rst = 1'b1;
        x   = 4'b1011;
        y   = 4'b0110;
        cin = 1'b1;

        apply(1'b1, 4'b1011, 4'b0110, 1'b1, 4'b0000, 1'b0, "reset1");
        apply(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, "reset2");

        apply(1'b0, 4'b0101, 4'b1010, 1'b0, 4'b1111, 1'b0, "5+10");
        apply(1'b0, 4'b1100, 4'b1011, 1'b0, 4'b0111, 1'b1, "12+11");
        apply(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, "full_ripple");
        apply(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "max_sum");
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "zero");

        apply(1'b0, 4'd3, 4'd4, 1'b0, 4'd7, 1'b0, "b2b_3+4");
        apply(1'b0, 4'd7, 4'd9, 1'b0, 4'd0, 1'b1, "b2b_7+9");
        apply(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, "b2b_0+0");

        apply(1'b0, 4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0, "pre_rst");
        apply(1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, "mid_rst");
        apply(1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, "post_rst");

        for (int i = 0; i < 512; i++) begin
            logic [W-1:0] xa;
            logic [W-1:0] ya;
            logic         ci;
            xa    = W'(i >> 5);
            ya    = W'(i >> 1);
            ci    = 1'(i);
            model = {1'b0, xa} + {1'b0, ya} + {{W{1'b0}}, ci};
            apply(1'b0, xa, ya, ci, model[W-1:0], model[W], "sweep");
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: got no completion by 100000, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
